// File: rtl/crc_stream_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : crc_stream_engine_if
//  Brief    : Beat-stream and result bundle for crc_stream_engine.
//  Revision : 1.0  initial release
// ============================================================================
interface crc_stream_engine_if #(
    parameter int unsigned CRC_W  = 8,
    parameter int unsigned DATA_W = 8
);
    logic              start;
    logic [CRC_W-1:0]  exp_crc;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              busy;
    logic              crc_valid;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_match;

    modport master (
        output start, exp_crc, in_valid, in_data, in_last,
        input  in_ready, busy, crc_valid, crc_out, crc_match
    );

    modport slave (
        input  start, exp_crc, in_valid, in_data, in_last,
        output in_ready, busy, crc_valid, crc_out, crc_match
    );
endinterface
`default_nettype wire

// File: rtl/crc_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module   : crc_stream_engine
//  Brief    : Streaming CRC generator/checker, one DATA_W-bit beat per cycle.
//             Optional zero-augmentation flush enabled by macro CRC_AUGMENT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module crc_stream_engine #(
    parameter int unsigned      CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = CRC_W'(8'h55),
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter int unsigned      DATA_W = 8
) (
    input  wire                  clk,
    input  wire                  rst_n,
    crc_stream_engine_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [CRC_W-1:0]  crc_q;
    logic [CRC_W-1:0]  exp_q;
    logic              ready_q;
    logic              busy_q;
    logic              valid_q;
    logic              match_q;
    logic [CRC_W-1:0]  crc_beat_d;
    logic              w_xfer;

`ifdef CRC_AUGMENT_EN
    localparam int unsigned CNT_W = $clog2(CRC_W + 1);
    logic [CNT_W-1:0]  cnt_q;
    logic [CRC_W-1:0]  crc_zero_d;

    assign crc_zero_d = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_q[CRC_W-1] ? POLY : '0);
`endif

    // start wins over any beat offered in the same cycle.
    assign bus.in_ready  = ready_q & ~bus.start;
    assign w_xfer        = bus.in_valid & bus.in_ready;

    assign bus.busy      = busy_q;
    assign bus.crc_valid = valid_q;
    assign bus.crc_match = match_q;
    assign bus.crc_out   = crc_q;

    always_comb begin
        crc_beat_d = crc_q;
        for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
            crc_beat_d = {crc_beat_d[CRC_W-2:0], bus.in_data[i]}
                       ^ (crc_beat_d[CRC_W-1] ? POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            crc_q   <= INIT;
            exp_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
`ifdef CRC_AUGMENT_EN
            cnt_q   <= '0;
`endif
        end else if (bus.start) begin
            state_q <= S_ACCUM;
            crc_q   <= INIT;
            exp_q   <= bus.exp_crc;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (w_xfer) begin
                        crc_q <= crc_beat_d;
                        if (bus.in_last) begin
                            ready_q <= 1'b0;
`ifdef CRC_AUGMENT_EN
                            state_q <= S_FLUSH;
                            cnt_q   <= CNT_W'(CRC_W);
`else
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            match_q <= (crc_beat_d == exp_q);
`endif
                        end
                    end
                end
`ifdef CRC_AUGMENT_EN
                // One zero bit per cycle; the final shift lands with crc_valid.
                S_FLUSH: begin
                    crc_q <= crc_zero_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        match_q <= (crc_zero_d == exp_q);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crc_stream_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crc_stream_engine
//  Brief    : Directed and legacy-equivalence bench, default (non-augmented) build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_crc_stream_engine;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   xfers  = 0;

    always #5 clk = ~clk;

    crc_stream_engine_if #(.CRC_W(8), .DATA_W(8)) bus ();

    crc_stream_engine #(
        .CRC_W (8),
        .POLY  (8'h55),
        .INIT  (8'h00),
        .DATA_W(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always @(posedge clk) if (bus.in_valid && bus.in_ready) xfers++;

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] exp_in;
        logic [7:0] crc;
        logic       match;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] legacy_crc(input logic [79:0] v);
        logic [7:0] c;
        logic       m;
        c = 8'h00;
        for (int i = 0; i < 80; i++) begin
            m = c[7];
            c = {c[6:0], v[79-i]};
            if (m) c = c ^ 8'h55;
        end
        return c;
    endfunction

    task automatic do_start(input logic [7:0] e, input logic offer, input logic [7:0] d);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.exp_crc  = e;
        bus.in_valid = offer;
        bus.in_data  = d;
        bus.in_last  = 1'b0;
        #1;
        check("ready_on_start", {31'd0, bus.in_ready}, 0);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check("valid_after_start", {31'd0, bus.crc_valid}, 0);
        check("match_after_start", {31'd0, bus.crc_match}, 0);
        check("busy_after_start",  {31'd0, bus.busy}, 1);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            bus.in_last  = 1'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        #1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic finish_frame(input logic [7:0] crc, input logic match);
        check("valid_before_result", {31'd0, bus.crc_valid}, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1;
        check("crc_valid", {31'd0, bus.crc_valid}, 1);
        check("crc_out",   {24'd0, bus.crc_out}, {24'd0, crc});
        check("crc_match", {31'd0, bus.crc_match}, {31'd0, match});
        check("busy_done", {31'd0, bus.busy}, 0);
        check("ready_done", {31'd0, bus.in_ready}, 0);
    endtask

    initial begin
        logic [79:0] v;
        logic [7:0]  m;
        logic [7:0]  e;
        int          x0;

        vt[0] = '{2, 8'h80, 8'h00, 8'h20, 8'h20, 1'b1};
        vt[1] = '{1, 8'h01, 8'h00, 8'h02, 8'h01, 1'b0};
        vt[2] = '{1, 8'hFF, 8'h00, 8'hFF, 8'hFF, 1'b1};
        vt[3] = '{2, 8'hFF, 8'h00, 8'h00, 8'hC0, 1'b0};
        vt[4] = '{1, 8'h80, 8'h00, 8'h80, 8'h80, 1'b1};
        vt[5] = '{1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1};

        bus.start    = 1'b0;
        bus.exp_crc  = 8'h00;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        bus.in_last  = 1'b1;

        // Reset state, with a beat being offered throughout.
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.in_ready}, 0);
        check("rst_busy",  {31'd0, bus.busy}, 0);
        check("rst_valid", {31'd0, bus.crc_valid}, 0);
        check("rst_crc",   {24'd0, bus.crc_out}, 0);
        check("rst_match", {31'd0, bus.crc_match}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", {31'd0, bus.in_ready}, 0);
        check("idle_busy",  {31'd0, bus.busy}, 0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            do_start(vt[i].exp_in, 1'b0, 8'h00);
            if (vt[i].n == 2) begin
                send_beat(vt[i].b0, 1'b0, i % 2);
                send_beat(vt[i].b1, 1'b1, 1);
            end else begin
                send_beat(vt[i].b0, 1'b1, i % 2);
            end
            finish_frame(vt[i].crc, vt[i].match);
        end

        // Result held across idle cycles; beats offered in DONE are ignored.
        do_start(8'h02, 1'b0, 8'h00);
        send_beat(8'h01, 1'b1, 0);
        finish_frame(8'h01, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hFF;
            bus.in_last  = 1'b1;
            #1;
            check("hold_valid", {31'd0, bus.crc_valid}, 1);
            check("hold_crc",   {24'd0, bus.crc_out}, 32'h01);
            check("hold_ready", {31'd0, bus.in_ready}, 0);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        // Abort mid-frame; the beat on the restart cycle must be dropped.
        do_start(8'h20, 1'b0, 8'h00);
        send_beat(8'hFF, 1'b0, 0);
        do_start(8'h20, 1'b1, 8'h80);
        send_beat(8'h80, 1'b0, 0);
        send_beat(8'h00, 1'b1, 0);
        finish_frame(8'h20, 1'b1);

        // Reset in the middle of a frame.
        do_start(8'h00, 1'b0, 8'h00);
        send_beat(8'hFF, 1'b0, 0);
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h80;
        @(negedge clk);
        #1;
        check("mid_rst_ready", {31'd0, bus.in_ready}, 0);
        check("mid_rst_busy",  {31'd0, bus.busy}, 0);
        check("mid_rst_valid", {31'd0, bus.crc_valid}, 0);
        check("mid_rst_crc",   {24'd0, bus.crc_out}, 0);
        check("mid_rst_match", {31'd0, bus.crc_match}, 0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        #1;
        check("post_rst_ready", {31'd0, bus.in_ready}, 0);
        bus.in_valid = 1'b0;

        // Legacy equivalence on random 80-bit vectors with random stalls.
        for (int f = 0; f < 200; f++) begin
            v = {$urandom, $urandom, 16'($urandom)};
            m = legacy_crc(v);
            e = (f % 2 == 0) ? m : 8'($urandom);
            do_start(e, 1'b0, 8'h00);
            x0 = xfers;
            for (int k = 0; k < 10; k++)
                send_beat(v[79-8*k -: 8], (k == 9), int'($urandom_range(0, 2)));
            finish_frame(m, (e == m));
            check("beat_count", xfers - x0, 10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
